// File: rtl/skintone_pipe_sched.sv
// Issue controller for the fixed-latency skin-tone transform pipelines.
// Credit-based issue into a non-stallable pipeline, results captured in a FWFT FIFO.
module skintone_pipe_sched #(
  parameter int unsigned PIPE_LAT   = 6,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FRAME_W    = 640,
  parameter int unsigned FRAME_H    = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_Y,
  input  logic [7:0] in_Cb,
  input  logic [7:0] in_Cr,
  output logic [7:0] pipe_Y,
  output logic [7:0] pipe_Cb,
  output logic [7:0] pipe_Cr,
  input  logic [7:0] pipe_cb_res,
  input  logic [7:0] pipe_cr_res,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_Cb,
  output logic [7:0] out_Cr,
  output logic       out_eol,
  output logic       out_eof
);

  localparam int unsigned TAG_N = PIPE_LAT + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned INF_W = $clog2(TAG_N + 1);
  localparam int unsigned CRD_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;
  localparam int unsigned COL_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int unsigned ROW_W = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic valid;
    logic eol;
    logic eof;
  } tag_t;

  typedef struct packed {
    logic [7:0] cb;
    logic [7:0] cr;
    logic       eol;
    logic       eof;
  } entry_t;

  state_t                 state;
  tag_t [TAG_N-1:0]       tags;
  tag_t                   new_tag;
  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  entry_t                 mem [FIFO_DEPTH];
  entry_t                 head;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_count;
  logic [INF_W-1:0]       inflight;
  logic [CRD_W-1:0]       credit_used;
  logic                   accept;
  logic                   last_col;
  logic                   last_row;
  logic                   eof_px;
  logic                   wr_en;
  logic                   rd_en;

  // Count of tags still travelling through the pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < TAG_N; i++) begin
      inflight = inflight + INF_W'(tags[i].valid);
    end
  end

  // Credit uses registered counts only, so freed slots show up one cycle later.
  assign credit_used = CRD_W'(fifo_count) + CRD_W'(inflight);
  assign in_ready    = (state == RUN) && (credit_used < CRD_W'(FIFO_DEPTH));
  assign accept      = in_valid && in_ready;

  assign last_col = (col == COL_W'(FRAME_W - 1));
  assign last_row = (row == ROW_W'(FRAME_H - 1));
  assign eof_px   = last_col && last_row;

  assign new_tag.valid = accept;
  assign new_tag.eol   = accept && last_col;
  assign new_tag.eof   = accept && eof_px;

  assign wr_en     = tags[TAG_N-1].valid;
  assign out_valid = (fifo_count != '0);
  assign rd_en     = out_valid && out_ready;

  assign head    = mem[rd_ptr];
  assign out_Cb  = out_valid ? head.cb  : 8'h00;
  assign out_Cr  = out_valid ? head.cr  : 8'h00;
  assign out_eol = out_valid ? head.eol : 1'b0;
  assign out_eof = out_valid ? head.eof : 1'b0;

  // Control FSM, pipeline issue, tag shift and FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      col        <= '0;
      row        <= '0;
      pipe_Y     <= 8'h00;
      pipe_Cb    <= 8'h00;
      pipe_Cr    <= 8'h00;
      tags       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      done <= 1'b0;
      tags <= {tags[TAG_N-2:0], new_tag};

      if (accept) begin
        pipe_Y  <= in_Y;
        pipe_Cb <= in_Cb;
        pipe_Cr <= in_Cr;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            col   <= '0;
            row   <= '0;
          end
        end
        RUN: begin
          if (accept && eof_px) state <= DRAIN;
        end
        DRAIN: begin
          if ((fifo_count == '0) && (inflight == '0)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({wr_en, rd_en})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{cb: pipe_cb_res, cr: pipe_cr_res,
                       eol: tags[TAG_N-1].eol, eof: tags[TAG_N-1].eof};
    end
  end

  // Credit accounting must make a write into a full FIFO impossible.
  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_skintone_pipe_sched.sv
// Self-checking bench for skintone_pipe_sched: a transaction-level reference model
// plus a table of frame scenarios and hand-written corner-case sequences.
module tb_skintone_pipe_sched;

  localparam int unsigned PIPE_LAT   = 6;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned FRAME_W    = 4;
  localparam int unsigned FRAME_H    = 2;
  localparam int          NPIX       = FRAME_W * FRAME_H;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_Y, in_Cb, in_Cr;
  logic [7:0] pipe_Y, pipe_Cb, pipe_Cr;
  logic [7:0] pipe_cb_res, pipe_cr_res;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_Cb, out_Cr;
  logic       out_eol, out_eof;

  skintone_pipe_sched #(
    .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_Y(in_Y), .in_Cb(in_Cb), .in_Cr(in_Cr),
    .pipe_Y(pipe_Y), .pipe_Cb(pipe_Cb), .pipe_Cr(pipe_Cr),
    .pipe_cb_res(pipe_cb_res), .pipe_cr_res(pipe_cr_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_Cb(out_Cb), .out_Cr(out_Cr),
    .out_eol(out_eol), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  // Stand-in for the transform pipelines: cb^FF and cr+1 after PIPE_LAT edges.
  logic [15:0] pipe_sh [PIPE_LAT];
  always @(posedge clk) begin
    pipe_sh[0] <= {pipe_Cb ^ 8'hFF, pipe_Cr + 8'd1};
    for (int k = 1; k < PIPE_LAT; k++) pipe_sh[k] <= pipe_sh[k-1];
  end
  assign pipe_cb_res = pipe_sh[PIPE_LAT-1][15:8];
  assign pipe_cr_res = pipe_sh[PIPE_LAT-1][7:0];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: frame phase, outstanding pixel count and expected result queue.
  typedef struct {
    logic [7:0] cb;
    logic [7:0] cr;
    logic       eol;
    logic       eof;
    int         vis;
  } exp_t;

  exp_t       q[$];
  int         m_st;      // 0 idle, 1 accepting, 2 draining
  int         m_out;
  int         m_idx;
  logic       m_done;
  logic [7:0] m_y, m_cb, m_cr;
  int         del_total   = 0;
  int         dut_acc_cnt = 0;
  int         dut_done_cnt = 0;

  task automatic reset_model();
    q.delete();
    m_st = 0; m_out = 0; m_idx = 0; m_done = 1'b0;
    m_y = 8'h00; m_cb = 8'h00; m_cr = 8'h00;
  endtask

  initial reset_model();

  always @(negedge clk) begin
    if (rst) begin
      reset_model();
    end else begin
      logic exp_rdy, exp_ov, n_done;
      exp_t e;
      exp_rdy = (m_st == 1) && (m_out < FIFO_DEPTH);
      exp_ov  = (q.size() > 0) && (q[0].vis <= cyc);
      chk("busy", busy, m_st != 0);
      chk("done", done, m_done);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, exp_ov);
      chk("pipe_Y", pipe_Y, m_y);
      chk("pipe_Cb", pipe_Cb, m_cb);
      chk("pipe_Cr", pipe_Cr, m_cr);
      if (exp_ov && out_valid) begin
        chk("out_Cb", out_Cb, q[0].cb);
        chk("out_Cr", out_Cr, q[0].cr);
        chk("out_eol", out_eol, q[0].eol);
        chk("out_eof", out_eof, q[0].eof);
      end
      if (in_valid && in_ready) dut_acc_cnt++;
      if (done) dut_done_cnt++;

      n_done = (m_st == 2) && (m_out == 0);
      if (exp_ov && out_ready) begin
        void'(q.pop_front());
        m_out--;
        del_total++;
      end
      if (in_valid && exp_rdy) begin
        e.cb  = in_Cb ^ 8'hFF;
        e.cr  = in_Cr + 8'd1;
        e.eol = ((m_idx % FRAME_W) == FRAME_W - 1);
        e.eof = (m_idx == NPIX - 1);
        e.vis = cyc + PIPE_LAT + 2;
        q.push_back(e);
        m_out++;
        m_y = in_Y; m_cb = in_Cb; m_cr = in_Cr;
        m_idx++;
        if (e.eof) m_st = 2;
      end
      if (n_done) m_st = 0;
      else if (m_st == 0 && start) begin
        m_st  = 1;
        m_idx = 0;
      end
      m_done = n_done;
    end
  end

  // One clock of stimulus; vm/rm select in_valid / out_ready patterns.
  task automatic tick(input int vm, input int rm);
    @(posedge clk);
    #1;
    start = 1'b0;
    in_Y  = 8'($urandom);
    in_Cb = 8'($urandom);
    in_Cr = 8'($urandom);
    case (vm)
      0:       in_valid = 1'b1;
      1:       in_valid = (cyc % 3 == 0);
      2:       in_valid = 1'($urandom_range(0, 1));
      default: in_valid = 1'b0;
    endcase
    case (rm)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      2:       out_ready = cyc[0];
      default: out_ready = 1'b1 & 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_done(input int vm, input int rm, input int budget);
    int d0 = dut_done_cnt;
    int n  = 0;
    while (dut_done_cnt == d0 && n < budget) begin
      tick(vm, rm);
      n++;
    end
    if (dut_done_cnt == d0) chk("done_timeout", 0, 1);
  endtask

  task automatic run_frames(input int vm, input int rm, input int nf);
    for (int f = 0; f < nf; f++) begin
      @(posedge clk);
      #1 start = 1'b1;
      wait_done(vm, rm, 400);
    end
  endtask

  typedef struct {
    int vm;
    int rm;
    int nf;
    int exp_px;
    int exp_done;
  } scen_t;

  scen_t tbl [5];
  int a0, d0, n0;

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{vm: 0, rm: 0, nf: 2, exp_px: 2 * NPIX, exp_done: 2};
    tbl[1] = '{vm: 0, rm: 2, nf: 4, exp_px: 4 * NPIX, exp_done: 4};
    tbl[2] = '{vm: 1, rm: 0, nf: 1, exp_px: NPIX,     exp_done: 1};
    tbl[3] = '{vm: 2, rm: 3, nf: 3, exp_px: 3 * NPIX, exp_done: 3};
    tbl[4] = '{vm: 1, rm: 2, nf: 2, exp_px: 2 * NPIX, exp_done: 2};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_Y = 8'h00; in_Cb = 8'h00; in_Cr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pipe_Y", pipe_Y, 0);
    chk("rst_out_Cb", out_Cb, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // First-result latency and data with a fixed pixel value.
    #1;
    a0 = dut_acc_cnt; d0 = dut_done_cnt; n0 = del_total;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_Y = 8'h55; in_Cb = 8'h10; in_Cr = 8'h20;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      if (e == 1) chk("lat_in_ready", in_ready, 1);
      if (e == 8) chk("lat_no_early_valid", out_valid, 0);
      if (e == 9) begin
        chk("lat_first_valid", out_valid, 1);
        chk("lat_out_Cb", out_Cb, 8'hEF);
        chk("lat_out_Cr", out_Cr, 8'h21);
      end
    end
    wait_done(0, 0, 100);
    chk("f1_accepts", dut_acc_cnt - a0, NPIX);
    chk("f1_delivered", del_total - n0, NPIX);
    chk("f1_dones", dut_done_cnt - d0, 1);

    // Backpressure: credits stop issue at exactly FIFO_DEPTH pixels.
    a0 = dut_acc_cnt; d0 = dut_done_cnt; n0 = del_total;
    @(posedge clk);
    #1 start = 1'b1;
    repeat (25) tick(0, 1);
    chk("bp_accepts", dut_acc_cnt - a0, FIFO_DEPTH);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_busy", busy, 1);
    wait_done(0, 0, 100);
    chk("bp_delivered", del_total - n0, NPIX);
    chk("bp_dones", dut_done_cnt - d0, 1);

    // start while busy is ignored.
    a0 = dut_acc_cnt; d0 = dut_done_cnt; n0 = del_total;
    @(posedge clk);
    #1 start = 1'b1;
    repeat (3) tick(0, 0);
    start = 1'b1;
    wait_done(0, 0, 100);
    chk("sr_accepts", dut_acc_cnt - a0, NPIX);
    chk("sr_delivered", del_total - n0, NPIX);
    chk("sr_dones", dut_done_cnt - d0, 1);

    // Reset with 3 pixels in flight and 2 in the FIFO.
    d0 = dut_done_cnt;
    @(posedge clk);
    #1 start = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    repeat (5) tick(0, 1);
    repeat (5) tick(3, 1);
    chk("mr_out_valid", out_valid, 1);
    chk("mr_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mr_busy0", busy, 0);
    chk("mr_done0", done, 0);
    chk("mr_in_ready0", in_ready, 0);
    chk("mr_out_valid0", out_valid, 0);
    chk("mr_pipe0", {8'h00, pipe_Y, pipe_Cb, pipe_Cr}, 0);
    chk("mr_out0", {14'h0, out_Cb, out_Cr, out_eol, out_eof}, 0);
    repeat (2) tick(3, 0);
    rst = 1'b0;
    repeat (12) tick(3, 0);
    chk("mr_no_done", dut_done_cnt - d0, 0);
    a0 = dut_acc_cnt; n0 = del_total;
    run_frames(0, 0, 1);
    chk("mr_clean_accepts", dut_acc_cnt - a0, NPIX);
    chk("mr_clean_delivered", del_total - n0, NPIX);
    chk("mr_clean_dones", dut_done_cnt - d0, 1);

    // Table of frame scenarios.
    for (int i = 0; i < 5; i++) begin
      a0 = dut_acc_cnt; d0 = dut_done_cnt; n0 = del_total;
      run_frames(tbl[i].vm, tbl[i].rm, tbl[i].nf);
      chk($sformatf("tbl%0d_accepts", i), dut_acc_cnt - a0, tbl[i].exp_px);
      chk($sformatf("tbl%0d_delivered", i), del_total - n0, tbl[i].exp_px);
      chk($sformatf("tbl%0d_dones", i), dut_done_cnt - d0, tbl[i].exp_done);
    end
    repeat (4) tick(3, 0);
    chk("end_idle", busy, 0);
    chk("end_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/skintone_pipe_sched.md
Name: skintone_pipe_sched

Overview:
- Issue controller for the fixed-latency skin-tone transform pipelines (transcb/transcr). Those pipelines have no stall input.
- Accepts a valid/ready YCbCr pixel stream for one frame per start command.
- Drives the pipeline inputs and tracks in-flight pixels with a tag shift register.
- Captures results into an output FIFO. Credit-based issue guarantees no result is ever dropped under downstream backpressure.

Parameters:
- PIPE_LAT, 6: clock edges from a change on pipe_Y/pipe_Cb/pipe_Cr to the corresponding result appearing on pipe_cb_res/pipe_cr_res.
- FIFO_DEPTH, 8: output FIFO entries. Power of two, ≥ 2.
- FRAME_W, 640: pixels per line.
- FRAME_H, 480: lines per frame.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: pulse; begins a frame when IDLE.
- busy, output, 1: high in RUN or DRAIN.
- done, output, 1: one-cycle pulse at frame completion.
- in_valid, input, 1: input pixel valid.
- in_ready, output, 1: input pixel accepted when in_valid && in_ready at a rising edge.
- in_Y / in_Cb / in_Cr, input, 8 each: input pixel.
- pipe_Y / pipe_Cb / pipe_Cr, output, 8 each: registered pipeline inputs.
- pipe_cb_res / pipe_cr_res, input, 8 each: pipeline results.
- out_valid, output, 1: FIFO head valid.
- out_ready, input, 1: downstream accept.
- out_Cb / out_Cr, output, 8 each: FIFO head data.
- out_eol, output, 1: head is the last pixel of a line.
- out_eof, output, 1: head is the last pixel of the frame.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - busy=0, done=0, in_ready=0, out_valid=0.
  - pipe_*=0, out_* data and flags=0.
  - Tags, FIFO pointers/count, col/row counters all cleared.
  - Reset mid-frame discards all in-flight and buffered pixels. No done pulse.
- State IDLE:
  - in_ready=0.
  - start=1 goes to RUN and clears col/row.
- State RUN:
  - in_ready = (fifo_count + inflight) < FIFO_DEPTH. Combinational from registered state only, never from in_valid.
  - Accept at edge t: pipe_Y/Cb/Cr load the input pixel at edge t. A tag {valid=1, eol, eof} enters tag stage 0.
  - eol = (col==FRAME_W-1). eof = eol && (row==FRAME_H-1).
  - col wraps to 0 and row increments on eol.
  - pipe_* hold their value when nothing is accepted.
  - Accepting the eof pixel goes to DRAIN at the same edge. in_ready=0 from then on.
- State DRAIN:
  - in_ready=0.
  - When inflight==0 and the FIFO is empty: done=1 for one cycle, then IDLE.
- start while busy is ignored.
- Tag pipeline:
  - PIPE_LAT+1 stages; shifts every cycle.
  - Stage 0 is zero when nothing is accepted.
  - inflight = number of valid tags.
  - When the last stage is valid, {pipe_cb_res, pipe_cr_res, eol, eof} is written to the FIFO. The pixel accepted at edge t is written at edge t+PIPE_LAT+1.
- FIFO:
  - Read on out_valid && out_ready. out_valid = count != 0. out_* show the head, first-word fall-through.
  - Simultaneous read and write at any count: count unchanged; both pointers advance and wrap at FIFO_DEPTH.
  - A write when full is impossible by construction; assert it in verification.
- Credit boundary:
  - Reads and tag retirements free credit only on the following cycle. in_ready uses registered counts.
- Throughput: 1 pixel/cycle with out_ready held at 1.

Test Plan:
- FRAME_W=4, FRAME_H=2, in_valid=1, out_ready=1. Pipeline model returns res = Cb^8'hFF and Cr+1. Start → 8 accepts on consecutive cycles; first out_valid 7 cycles after the first accept.
  - out_Cb for Cb=8'h10 is 8'hEF.
  - out_eol on pixels 3 and 7; out_eof only on pixel 7.
  - done one cycle after the last read; busy falls with it.
- Same frame with out_ready=0 throughout → exactly FIFO_DEPTH=8 accepts, then in_ready=0.
  - FIFO fills to 8; no overflow assertion fires.
  - Raising out_ready drains all 8 in order.
- out_ready toggling 1/0 each cycle over a FRAME_W=8, FRAME_H=4 frame → all 32 pixels are delivered in order with correct data, eol and eof; done fires exactly once.
- start pulsed during RUN → ignored; col/row not cleared; pixel count still 8.
- rst asserted with 3 pixels in flight and 2 in the FIFO → all outputs 0 immediately, in IDLE.
  - A new start after release produces a clean frame.
  - No stale pixels appear; no done pulse for the aborted frame.
- in_valid gapped (1 cycle on, 2 off) → pipe_* hold between accepts. Results are correct and spaced with 2-cycle gaps.
